// File: rtl/phase_lock_seq.sv
// Lock sequencer around phase_adjust_fsm: arms the FSM, gates averaging while the delay line
// settles, retries on timeout and walks phase_code_out to the locked code. Option: PHASE_LOCK_SEQ_STEP_EN.
module phase_lock_seq #(
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned DROP_CYC    = 16,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned STEP_CYC    = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       cal_req,
  input  logic       phase_locked,
  input  logic [3:0] phase_sel_code,
  output logic       start_phase_lock,
  output logic       enable,
  output logic [3:0] phase_code_out,
  output logic       cal_done,
  output logic       cal_err,
  output logic [1:0] retry_cnt
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DW = $clog2(DROP_CYC + 1);

  if (SETTLE_CYC < 1 || DROP_CYC < 1 || STEP_CYC < 1 || MAX_RETRY > 3 ||
      TIMEOUT_CYC <= DROP_CYC) begin : g_bad_cfg
    $error("phase_lock_seq: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_LOCK, S_DROP, S_APPLY, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [TW-1:0]   tout_q, tout_d;
  logic [DW-1:0]   drop_q, drop_d;
  logic [3:0]      target_q, target_d;
  logic [3:0]      sel_q;
  logic [3:0]      code_d;
  logic [1:0]      retry_d;
  logic            start_d, enable_d, done_d, err_d;
`ifdef PHASE_LOCK_SEQ_STEP_EN
  localparam int unsigned PW = $clog2(STEP_CYC + 1);
  logic [PW-1:0]   step_q, step_d;
  logic [3:0]      dist;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      settle_q         <= '0;
      tout_q           <= '0;
      drop_q           <= '0;
      target_q         <= '0;
      sel_q            <= '0;
      start_phase_lock <= 1'b0;
      enable           <= 1'b0;
      phase_code_out   <= '0;
      cal_done         <= 1'b0;
      cal_err          <= 1'b0;
      retry_cnt        <= '0;
`ifdef PHASE_LOCK_SEQ_STEP_EN
      step_q           <= '0;
`endif
    end else begin
      state_q          <= state_d;
      settle_q         <= settle_d;
      tout_q           <= tout_d;
      drop_q           <= drop_d;
      target_q         <= target_d;
      sel_q            <= phase_sel_code;
      start_phase_lock <= start_d;
      enable           <= enable_d;
      phase_code_out   <= code_d;
      cal_done         <= done_d;
      cal_err          <= err_d;
      retry_cnt        <= retry_d;
`ifdef PHASE_LOCK_SEQ_STEP_EN
      step_q           <= step_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tout_d   = tout_q;
    drop_d   = drop_q;
    target_d = target_q;
    code_d   = phase_code_out;
    retry_d  = retry_cnt;
`ifdef PHASE_LOCK_SEQ_STEP_EN
    step_d   = step_q;
    dist     = target_q - phase_code_out;
`endif

    unique case (state_q)
      S_IDLE: begin
        retry_d = '0;
        if (cal_req) state_d = S_ARM;
      end
      S_ARM: begin
        settle_d = SW'(SETTLE_CYC);
        tout_d   = '0;
        state_d  = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        tout_d = tout_q + TW'(1);
        if (phase_sel_code != sel_q)  settle_d = SW'(SETTLE_CYC);
        else if (settle_q != '0)      settle_d = settle_q - SW'(1);
        // Lock is checked first so a lock on the last timeout cycle is still taken.
        if (phase_locked && tout_q >= TW'(DROP_CYC)) begin
          target_d = phase_sel_code;
          state_d  = S_APPLY;
`ifdef PHASE_LOCK_SEQ_STEP_EN
          step_d   = '0;
`endif
        end else if (tout_q == TW'(TIMEOUT_CYC - 1)) begin
          if (retry_cnt < 2'(MAX_RETRY)) begin
            retry_d = retry_cnt + 2'd1;
            drop_d  = '0;
            state_d = S_DROP;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DROP: begin
        if (drop_q == DW'(DROP_CYC - 1)) state_d = S_ARM;
        else                             drop_d  = drop_q + DW'(1);
      end
      S_APPLY: begin
        if (phase_code_out == target_q) begin
          state_d = S_DONE;
        end else begin
`ifdef PHASE_LOCK_SEQ_STEP_EN
          // Shortest modulo-16 direction; a distance of exactly 8 steps up.
          if (step_q == PW'(STEP_CYC - 1)) begin
            step_d = '0;
            code_d = (dist <= 4'd8) ? phase_code_out + 4'd1 : phase_code_out - 4'd1;
          end else begin
            step_d = step_q + PW'(1);
          end
`else
          code_d = target_q;
`endif
        end
      end
      S_DONE, S_ERR: ;
      default: state_d = S_IDLE;
    endcase

    // Abort leaves phase_code_out untouched so the delay line never glitches.
    if (!cal_req) begin
      state_d  = S_IDLE;
      settle_d = '0;
      tout_d   = '0;
      drop_d   = '0;
      retry_d  = '0;
      code_d   = phase_code_out;
`ifdef PHASE_LOCK_SEQ_STEP_EN
      step_d   = '0;
`endif
    end

    start_d  = (state_d == S_ARM) || (state_d == S_WAIT_LOCK) ||
               (state_d == S_APPLY) || (state_d == S_DONE);
    enable_d = (state_d == S_WAIT_LOCK) && (settle_d == '0);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
  end

endmodule
